// File: rtl/time_set_ctrl.sv
// Time-setting mode controller for a clock display.
// Drives count pulses, mode state and field blinking.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   btn_mode/up/down    debounced one-cycle button pulses
//   sec_co, min_co      carry pulses from sec/min counters
//   sec_en/min_en/hr_en count-up pulses (registered)
//   sec_di/min_di/hr_di count-down pulses (registered)
//   state               00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   blink_mask          {hr, min, sec} blanking bits
module time_set_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000,
    parameter int IDLE_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_di,
    output logic       min_di,
    output logic       hr_di,
    output logic [1:0] state,
    output logic [2:0] blink_mask
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
    localparam logic [3:0]    IMAX = 4'(IDLE_SEC);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    state_t        st_q, st_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [3:0]    idle_q, idle_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [2:0]    en_d, di_d, mask_d;

    logic in_set, run, wrap, chg, any_btn, req_up, req_dn;
    logic sel_hr, sel_min, sel_sec;

    always_comb begin
        st_d    = st_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        idle_d  = idle_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        en_d    = 3'b000;
        di_d    = 3'b000;
        mask_d  = 3'b000;

        in_set  = (st_q != RUN);
        run     = (st_q == RUN);
        wrap    = (presc_q == PMAX);
        any_btn = btn_mode | btn_up | btn_down;
        sel_hr  = (st_q == SET_HR);
        sel_min = (st_q == SET_MIN);
        sel_sec = (st_q == SET_SEC);

        // mode press wins; any press counts as activity
        if (btn_mode)
            st_d = state_t'(st_q + 2'd1);
        else if (in_set && !any_btn && idle_q == IMAX)
            st_d = RUN;
        chg = (st_d != st_q);

        // tick is registered, so sec_en lands two edges after wrap
        if (chg || wrap)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;
        tick_d = wrap && !chg;

        if (!in_set || chg || any_btn)
            idle_d = 4'd0;
        else if (wrap)
            idle_d = idle_q + 4'd1;

        if (!in_set || chg) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BMAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end

        // up/down pair or mode press cancels the request
        req_up = in_set && btn_up && !btn_down && !btn_mode;
        req_dn = in_set && btn_down && !btn_up && !btn_mode;

        en_d[0] = (run && tick_q) || (req_up && sel_sec);
        en_d[1] = (run && sec_co) || (req_up && sel_min);
        en_d[2] = (run && min_co) || (req_up && sel_hr);
        di_d    = {req_dn && sel_hr, req_dn && sel_min, req_dn && sel_sec};

        unique case (st_d)
            SET_HR:  mask_d = {phase_d, 2'b00};
            SET_MIN: mask_d = {1'b0, phase_d, 1'b0};
            SET_SEC: mask_d = {2'b00, phase_d};
            default: mask_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= RUN;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            idle_q     <= 4'd0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            sec_en     <= 1'b0;
            min_en     <= 1'b0;
            hr_en      <= 1'b0;
            sec_di     <= 1'b0;
            min_di     <= 1'b0;
            hr_di      <= 1'b0;
            blink_mask <= 3'b000;
        end else begin
            st_q       <= st_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            idle_q     <= idle_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            sec_en     <= en_d[0];
            min_en     <= en_d[1];
            hr_en      <= en_d[2];
            sec_di     <= di_d[0];
            min_di     <= di_d[1];
            hr_di      <= di_d[2];
            blink_mask <= mask_d;
        end
    end

    assign state = st_q;

endmodule
